nfca_rx_bitdec: RTL and testbench

- Consumes the 2.5425 Msa/s ASK-demodulated stream (rx_ask_en/rx_ask) from the RX DSP stage.
- Decodes ISO14443A PICC→PCD Manchester coding with an 847.5 kHz subcarrier into a bit stream with start/end-of-frame and collision information.
- Feeds the frame assembler in nfca_controller.
- At 32 clk per sample: 1 bit = 24 samples, 1 half-bit = 12 samples, 1 subcarrier period = 3 samples.

---
 rtl/nfca_rx_bitdec_pkg.sv | 31 +++
 rtl/nfca_rx_bitdec_halfbit_win.sv | 47 ++++
 rtl/nfca_rx_bitdec.sv | 170 +++++++++++++++++
 tb/tb_nfca_rx_bitdec.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfca_rx_bitdec_pkg.sv
// Shared types for the ISO14443A PICC->PCD bit decoder: FSM states, Manchester
// symbols and the symbol classifier used by nfca_rx_bitdec.
package nfca_pkg;

  localparam int NFCA_SAMPLES_PER_BIT = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOF  = 2'd1,
    DATA = 2'd2
  } nfca_rxdec_state_t;

  typedef enum logic [1:0] {
    SYM_D = 2'd0,
    SYM_E = 2'd1,
    SYM_F = 2'd2,
    SYM_X = 2'd3
  } nfca_sym_t;

  function automatic nfca_sym_t nfca_sym(input logic first_mod, input logic second_mod);
    nfca_sym_t s;
    case ({first_mod, second_mod})
      2'b10:   s = SYM_D;
      2'b01:   s = SYM_E;
      2'b00:   s = SYM_F;
      default: s = SYM_X;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/nfca_rx_bitdec_halfbit_win.sv
// Half-bit window: counts sample strobes and modulated samples, and classes the
// window as modulated on the strobe that closes it (closing sample included).
module nfca_rx_halfbit_win #(
  parameter int HALF_SAMPLES = 12,
  parameter int MOD_THRESH   = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic rx_ask_en,
  input  logic rx_ask,
  output logic half_done,
  output logic half_mod
);

  localparam int WCW = $clog2(HALF_SAMPLES);

  logic [WCW-1:0] r_wcnt;
  logic [3:0]     r_mcnt;
  logic [3:0]     w_mcnt_fin;
  logic           w_last;

  // mcnt saturates at 15 so long windows cannot wrap back under the threshold
  assign w_mcnt_fin = (rx_ask && (r_mcnt != 4'hF)) ? r_mcnt + 4'd1 : r_mcnt;
  assign w_last     = (r_wcnt == WCW'(HALF_SAMPLES - 1));
  assign half_done  = rx_ask_en && w_last && !clr;
  assign half_mod   = (w_mcnt_fin >= 4'(MOD_THRESH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wcnt <= '0;
      r_mcnt <= '0;
    end else if (clr) begin
      r_wcnt <= '0;
      r_mcnt <= '0;
    end else if (rx_ask_en) begin
      if (w_last) begin
        r_wcnt <= '0;
        r_mcnt <= '0;
      end else begin
        r_wcnt <= r_wcnt + 1'b1;
        r_mcnt <= w_mcnt_fin;
      end
    end
  end

endmodule

// File: rtl/nfca_rx_bitdec.sv
// ISO14443A PICC->PCD Manchester bit decoder (SOF / data / EOF / collision).
// Build option: define NFCA_RX_COLLISION_EN to report X symbols as collision bits.
module nfca_rx_bitdec
  import nfca_pkg::*;
#(
  parameter int HALF_SAMPLES = NFCA_SAMPLES_PER_BIT / 2,
  parameter int MOD_THRESH   = 4,
  parameter int MAX_BITS     = 4095
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_on,
  input  logic        rx_ask_en,
  input  logic        rx_ask,
  output logic        rx_sof,
  output logic        rx_bit_en,
  output logic        rx_bit,
  output logic        rx_bit_col,
  output logic        rx_end,
  output logic        rx_end_err,
  output logic [11:0] rx_bit_cnt,
  output logic [1:0]  dbg_state
);

  nfca_rxdec_state_t r_state, w_nxt_state;
  logic        r_half, w_nxt_half;
  logic        r_first_mod, w_nxt_first_mod;
  logic        r_sof, w_nxt_sof;
  logic        r_bit_en, w_nxt_bit_en;
  logic        r_bit, w_nxt_bit;
  logic        r_col, w_nxt_col;
  logic        r_end, w_nxt_end;
  logic        r_end_err, w_nxt_end_err;
  logic [11:0] r_cnt, w_nxt_cnt;
  logic        w_clr, w_half_done, w_half_mod, w_full;
  nfca_sym_t   w_sym;

  // In IDLE the window is held clear until the first modulated sample, which
  // then becomes sample 0 of the SOF first half.
  assign w_clr  = !rx_on || ((r_state == IDLE) && !(rx_ask_en && rx_ask));
  assign w_sym  = nfca_sym(r_first_mod, w_half_mod);
  assign w_full = (r_cnt == 12'(MAX_BITS));

  nfca_rx_halfbit_win #(
    .HALF_SAMPLES(HALF_SAMPLES),
    .MOD_THRESH  (MOD_THRESH)
  ) u_win (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (w_clr),
    .rx_ask_en(rx_ask_en),
    .rx_ask   (rx_ask),
    .half_done(w_half_done),
    .half_mod (w_half_mod)
  );

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_half      = r_half;
    w_nxt_first_mod = r_first_mod;
    w_nxt_sof       = 1'b0;
    w_nxt_bit_en    = 1'b0;
    w_nxt_bit       = r_bit;
    w_nxt_col       = r_col;
    w_nxt_end       = 1'b0;
    w_nxt_end_err   = r_end_err;
    w_nxt_cnt       = r_cnt;
    if (!rx_on) begin
      w_nxt_state = IDLE;
      w_nxt_half  = 1'b0;
      if (r_state == DATA) begin
        w_nxt_end     = 1'b1;
        w_nxt_end_err = 1'b1;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_nxt_half = 1'b0;
          if (rx_ask_en && rx_ask) w_nxt_state = SOF;
        end
        SOF, DATA: begin
          if (w_half_done) begin
            if (!r_half) begin
              w_nxt_first_mod = w_half_mod;
              w_nxt_half      = 1'b1;
            end else begin
              w_nxt_half = 1'b0;
              if (r_state == SOF) begin
                if (w_sym == SYM_D) begin
                  w_nxt_sof   = 1'b1;
                  w_nxt_cnt   = '0;
                  w_nxt_state = DATA;
                end else begin
                  w_nxt_state = IDLE;
                end
              end else if (w_sym == SYM_F) begin
                w_nxt_end     = 1'b1;
                w_nxt_end_err = (r_cnt == '0);
                w_nxt_state   = IDLE;
              end else if (w_full) begin
                w_nxt_end     = 1'b1;
                w_nxt_end_err = 1'b1;
                w_nxt_state   = IDLE;
              end else if (w_sym == SYM_X) begin
`ifdef NFCA_RX_COLLISION_EN
                w_nxt_bit_en = 1'b1;
                w_nxt_bit    = 1'b1;
                w_nxt_col    = 1'b1;
                w_nxt_cnt    = r_cnt + 12'd1;
`else
                w_nxt_end     = 1'b1;
                w_nxt_end_err = 1'b1;
                w_nxt_state   = IDLE;
`endif
              end else begin
                w_nxt_bit_en = 1'b1;
                w_nxt_bit    = (w_sym == SYM_D);
                w_nxt_col    = 1'b0;
                w_nxt_cnt    = r_cnt + 12'd1;
              end
            end
          end
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_half      <= 1'b0;
      r_first_mod <= 1'b0;
      r_sof       <= 1'b0;
      r_bit_en    <= 1'b0;
      r_bit       <= 1'b0;
      r_col       <= 1'b0;
      r_end       <= 1'b0;
      r_end_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_half      <= w_nxt_half;
      r_first_mod <= w_nxt_first_mod;
      r_sof       <= w_nxt_sof;
      r_bit_en    <= w_nxt_bit_en;
      r_bit       <= w_nxt_bit;
      r_col       <= w_nxt_col;
      r_end       <= w_nxt_end;
      r_end_err   <= w_nxt_end_err;
      r_cnt       <= w_nxt_cnt;
    end
  end

  assign rx_sof     = r_sof;
  assign rx_bit_en  = r_bit_en;
  assign rx_bit     = r_bit;
  assign rx_end     = r_end;
  assign rx_end_err = r_end_err;
  assign rx_bit_cnt = r_cnt;
  assign dbg_state  = r_state;
`ifdef NFCA_RX_COLLISION_EN
  assign rx_bit_col = r_col;
`else
  assign rx_bit_col = 1'b0;
  logic w_unused_col;
  assign w_unused_col = r_col;
`endif

endmodule

// File: tb/tb_nfca_rx_bitdec.sv
// Directed bench for nfca_rx_bitdec: builds sample streams half-bit by half-bit
// and checks pulses, decoded bits, frame end status and bit count.
module tb_nfca_rx_bitdec;

  logic        clk = 1'b0;
  logic        rstn, rx_on, rx_ask_en, rx_ask;
  logic        rx_sof, rx_bit_en, rx_bit, rx_bit_col, rx_end, rx_end_err;
  logic [11:0] rx_bit_cnt;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // observation state filled by the monitor
  int         cyc = 0;
  int         strobe_cyc = 0;
  int         end_cyc = 0;
  int         n_sof = 0;
  int         n_end = 0;
  int         n_multi = 0;
  logic       last_err = 1'b0;
  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  nfca_rx_bitdec dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_on     (rx_on),
    .rx_ask_en (rx_ask_en),
    .rx_ask    (rx_ask),
    .rx_sof    (rx_sof),
    .rx_bit_en (rx_bit_en),
    .rx_bit    (rx_bit),
    .rx_bit_col(rx_bit_col),
    .rx_end    (rx_end),
    .rx_end_err(rx_end_err),
    .rx_bit_cnt(rx_bit_cnt),
    .dbg_state (dbg_state)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rstn) begin
      if ((32'(rx_sof) + 32'(rx_bit_en) + 32'(rx_end)) > 1) n_multi++;
      if (rx_sof) n_sof++;
      if (rx_bit_en) got_q.push_back({rx_bit_col, rx_bit});
      if (rx_end) begin
        n_end++;
        last_err = rx_end_err;
        end_cyc  = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sample(input logic v);
    @(negedge clk);
    rx_ask_en  = 1'b1;
    rx_ask     = v;
    strobe_cyc = cyc;
    @(negedge clk);
    rx_ask_en = 1'b0;
    rx_ask    = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  // modulated half: 847.5 kHz subcarrier pattern 1,1,0 four times
  task automatic half(input logic m);
    for (int i = 0; i < 4; i++) begin
      sample(m);
      sample(m);
      sample(1'b0);
    end
  endtask

  task automatic sym(input logic a, input logic b);
    half(a);
    half(b);
  endtask

  task automatic data_bit(input logic b);
    if (b) sym(1'b1, 1'b0);
    else   sym(1'b0, 1'b1);
    exp_q.push_back({1'b0, b});
  endtask

  task automatic clear_obs();
    n_sof = 0;
    n_end = 0;
    last_err = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_bits(input string name);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s bit count: got %0d bits, expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL %s bit %0d {col,bit}: got %b, expected %b", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0; rx_on = 1'b0; rx_ask_en = 1'b0; rx_ask = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({rx_sof, rx_bit_en, rx_bit, rx_bit_col, rx_end, rx_end_err} !== 6'b0 || rx_bit_cnt !== 12'd0) begin
      n_err++;
      $display("FAIL reset outputs: got %b cnt %0d, expected 000000 cnt 0",
               {rx_sof, rx_bit_en, rx_bit, rx_bit_col, rx_end, rx_end_err}, rx_bit_cnt);
    end
    n_vec++;
    if (dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset state: got %0d, expected 0", dbg_state);
    end
    rstn = 1'b1;
    rx_on = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle();
    clear_obs();
    for (int i = 0; i < 500; i++) sample(1'b0);
    n_vec++;
    if (n_sof != 0 || n_end != 0 || got_q.size() != 0 || rx_bit_cnt !== 12'd0) begin
      n_err++;
      $display("FAIL idle pulses: got sof %0d end %0d bits %0d cnt %0d, expected all 0",
               n_sof, n_end, got_q.size(), rx_bit_cnt);
    end
  endtask

  task automatic test_frame();
    logic [7:0] pat;
    clear_obs();
    pat = 8'b1011_0010;
    sym(1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) data_bit(pat[i]);
    sym(1'b0, 1'b0);
    n_vec++;
    if (n_sof != 1) begin
      n_err++;
      $display("FAIL frame sof: got %0d pulses, expected 1", n_sof);
    end
    check_bits("frame");
    n_vec++;
    if (n_end != 1 || last_err !== 1'b0) begin
      n_err++;
      $display("FAIL frame end: got %0d ends err %b, expected 1 ends err 0", n_end, last_err);
    end
    n_vec++;
    if (end_cyc - strobe_cyc != 1) begin
      n_err++;
      $display("FAIL frame end latency: got %0d clk, expected 1", end_cyc - strobe_cyc);
    end
    n_vec++;
    if (rx_bit_cnt !== 12'd8) begin
      n_err++;
      $display("FAIL frame cnt: got %0d, expected 8", rx_bit_cnt);
    end
  endtask

  task automatic test_glitch();
    clear_obs();
    sample(1'b1);
    for (int i = 0; i < 23; i++) sample(1'b0);
    n_vec++;
    if (n_sof != 0 || n_end != 0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL glitch: got sof %0d end %0d state %0d, expected 0 0 0", n_sof, n_end, dbg_state);
    end
    n_vec++;
    if (rx_bit_cnt !== 12'd8) begin
      n_err++;
      $display("FAIL glitch cnt hold: got %0d, expected 8", rx_bit_cnt);
    end
  endtask

  task automatic test_collision();
    clear_obs();
    sym(1'b1, 1'b0);
    data_bit(1'b1);
    data_bit(1'b0);
    data_bit(1'b1);
    sym(1'b1, 1'b1);
    sym(1'b0, 1'b0);
`ifdef NFCA_RX_COLLISION_EN
    exp_q.push_back(2'b11);
    check_bits("collision");
    n_vec++;
    if (n_end != 1 || last_err !== 1'b0 || rx_bit_cnt !== 12'd4) begin
      n_err++;
      $display("FAIL collision end: got ends %0d err %b cnt %0d, expected 1 0 4", n_end, last_err, rx_bit_cnt);
    end
`else
    check_bits("collision");
    n_vec++;
    if (n_end != 1 || last_err !== 1'b1 || rx_bit_cnt !== 12'd3) begin
      n_err++;
      $display("FAIL collision end: got ends %0d err %b cnt %0d, expected 1 1 3", n_end, last_err, rx_bit_cnt);
    end
`endif
  endtask

  task automatic test_empty_frame();
    clear_obs();
    sym(1'b1, 1'b0);
    sym(1'b0, 1'b0);
    n_vec++;
    if (n_sof != 1 || n_end != 1 || last_err !== 1'b1 || rx_bit_cnt !== 12'd0) begin
      n_err++;
      $display("FAIL empty frame: got sof %0d ends %0d err %b cnt %0d, expected 1 1 1 0",
               n_sof, n_end, last_err, rx_bit_cnt);
    end
  endtask

  task automatic test_abort();
    clear_obs();
    sym(1'b1, 1'b0);
    data_bit(1'b1);
    data_bit(1'b0);
    data_bit(1'b1);
    data_bit(1'b0);
    data_bit(1'b1);
    check_bits("abort bits");
    @(negedge clk);
    rx_on = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rx_end !== 1'b1 || rx_end_err !== 1'b1 || rx_bit_cnt !== 12'd5) begin
      n_err++;
      $display("FAIL abort end: got end %b err %b cnt %0d, expected 1 1 5", rx_end, rx_end_err, rx_bit_cnt);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (n_end != 1 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL abort once: got ends %0d state %0d, expected 1 0", n_end, dbg_state);
    end
    rx_on = 1'b1;
    clear_obs();
    sym(1'b1, 1'b0);
    data_bit(1'b0);
    data_bit(1'b1);
    data_bit(1'b1);
    sym(1'b0, 1'b0);
    check_bits("after abort");
    n_vec++;
    if (n_sof != 1 || n_end != 1 || last_err !== 1'b0 || rx_bit_cnt !== 12'd3) begin
      n_err++;
      $display("FAIL after abort frame: got sof %0d ends %0d err %b cnt %0d, expected 1 1 0 3",
               n_sof, n_end, last_err, rx_bit_cnt);
    end
  endtask

  task automatic test_async_reset();
    clear_obs();
    sym(1'b1, 1'b0);
    data_bit(1'b1);
    data_bit(1'b1);
    half(1'b1);
    n_vec++;
    if (rx_bit_cnt !== 12'd2 || dbg_state !== 2'd2) begin
      n_err++;
      $display("FAIL pre-reset: got cnt %0d state %0d, expected 2 2", rx_bit_cnt, dbg_state);
    end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if (rx_bit_cnt !== 12'd0 || dbg_state !== 2'd0 || rx_end !== 1'b0) begin
      n_err++;
      $display("FAIL async reset: got cnt %0d state %0d end %b, expected 0 0 0", rx_bit_cnt, dbg_state, rx_end);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (n_end != 0) begin
      n_err++;
      $display("FAIL async reset end: got %0d ends, expected 0", n_end);
    end
  endtask

  task automatic test_exclusive();
    n_vec++;
    if (n_multi != 0) begin
      n_err++;
      $display("FAIL pulse exclusivity: got %0d overlapping cycles, expected 0", n_multi);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_frame();
    test_glitch();
    test_collision();
    for (int i = 0; i < 30; i++) sample(1'b0);
    test_empty_frame();
    test_abort();
    test_async_reset();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
